single_port_ram: RTL and testbench

- Synchronous single-port RAM with a request/ready handshake and out-of-range address detection.
- One port serves either a write or a read per accepted request, selected by wr_rd.
- Sits behind the `intf` bus interface in the RAM verification environment. The interface carries en, wr_rd, addr, din and valid as stimulus, and dout, ready and error as responses.

---
 rtl/single_port_ram_pkg.sv | 19 +
 rtl/single_port_ram_array.sv | 38 +++
 rtl/single_port_ram.sv | 91 +++++++++
 tb/tb_single_port_ram.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/single_port_ram_pkg.sv
// Shared defaults and enums for the single-port RAM.
// Imported by the top and the storage array.
package single_port_ram_pkg;

   localparam int DATA_WIDTH_D = 8;
   localparam int ADDR_WIDTH_D = 5;
   localparam int DEPTH_D      = 16;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

   typedef enum logic {
      ST_RESET  = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

endpackage

// File: rtl/single_port_ram_array.sv
// DEPTH x DATA_WIDTH register array.
// Synchronous write, synchronous clear, registered read.
module single_port_ram_array
   import single_port_ram_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_D,
   parameter int DEPTH      = DEPTH_D,
   parameter int IDX_W      = 4
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  we,
   input  logic                  re,
   input  logic [IDX_W-1:0]      idx,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rdata <= '0;
      end else begin
         if (we) begin
            mem[idx] <= wdata;
         end
         // rdata holds between reads
         if (re) begin
            rdata <= mem[idx];
         end
      end
   end

endmodule

// File: rtl/single_port_ram.sv
// Single-port RAM with request/ready handshake
// and out-of-range address error pulse.
module single_port_ram
   import single_port_ram_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_D,
   parameter int ADDR_WIDTH = ADDR_WIDTH_D,
   parameter int DEPTH      = DEPTH_D
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  en,
   input  logic                  wr_rd,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  valid,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  ready,
   output logic                  error
);

   localparam int IDX_W =
      (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // one spare bit so DEPTH == 2**ADDR_WIDTH fits
   localparam logic [ADDR_WIDTH:0] DEPTH_L =
      DEPTH[ADDR_WIDTH:0];

   state_e state_q;
   state_e state_d;

   logic accept;
   logic in_range;
   logic do_wr;
   logic do_rd;

   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q <= ST_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      unique case (state_q)
         ST_RESET: begin
            state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            ready = 1'b1;
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase
   end

   assign accept   = en & valid & ready & ~rstn;
   assign in_range = ({1'b0, addr} < DEPTH_L);

   assign do_wr = accept & in_range
                & (op_e'(wr_rd) == OP_WRITE);
   assign do_rd = accept & in_range
                & (op_e'(wr_rd) == OP_READ);

   always_ff @(posedge clk) begin
      if (rstn) begin
         error <= 1'b0;
      end else begin
         error <= accept & ~in_range;
      end
   end

   single_port_ram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
   ) u_array (
      .clk   (clk),
      .clr   (rstn),
      .we    (do_wr),
      .re    (do_rd),
      .idx   (addr[IDX_W-1:0]),
      .wdata (din),
      .rdata (dout)
   );

endmodule

// File: tb/tb_single_port_ram.sv
// Directed + random bench for single_port_ram
// against an array-based reference model.
module tb_single_port_ram;

   logic       clk;
   logic       rstn;
   logic       en;
   logic       wr_rd;
   logic [4:0] addr;
   logic [7:0] din;
   logic       valid;
   logic [7:0] dout;
   logic       ready;
   logic       error;

   int checks = 0;
   int errors = 0;

   int         model [16];
   logic [7:0] exp_dout;
   logic       exp_rdy;
   logic       exp_err;

   single_port_ram dut (
      .clk   (clk),
      .rstn  (rstn),
      .en    (en),
      .wr_rd (wr_rd),
      .addr  (addr),
      .din   (din),
      .valid (valid),
      .dout  (dout),
      .ready (ready),
      .error (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   // one clock: drive, model the edge, check after it
   task automatic req(input string tag,
                      input bit rst, input bit e,
                      input bit v, input bit w,
                      input int a, input int d);
      bit acc;
      rstn  = rst;
      en    = e;
      valid = v;
      wr_rd = w;
      addr  = a[4:0];
      din   = d[7:0];
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 16; i++) model[i] = 0;
         exp_dout = 8'h00;
         exp_rdy  = 1'b0;
         exp_err  = 1'b0;
      end else begin
         acc     = e && v && exp_rdy;
         exp_err = acc && (a >= 16);
         if (acc && a < 16) begin
            if (w) model[a] = d & 8'hFF;
            else   exp_dout = model[a][7:0];
         end
         exp_rdy = 1'b1;
      end
      #1;
      chk({tag, "/dout"},  dout,  exp_dout);
      chk({tag, "/ready"}, ready, exp_rdy);
      chk({tag, "/error"}, error, exp_err);
      @(negedge clk);
   endtask

   initial begin
      int a;
      int d;
      exp_dout = 8'h00;
      exp_rdy  = 1'b0;
      exp_err  = 1'b0;
      rstn  = 1'b1;
      en    = 1'b0;
      valid = 1'b0;
      wr_rd = 1'b0;
      addr  = '0;
      din   = '0;

      // reset for 3 cycles, with a request that must drop
      req("rst0", 1, 1, 1, 1, 1, 8'h99);
      req("rst1", 1, 0, 0, 0, 0, 0);
      req("rst2", 1, 0, 0, 0, 0, 0);
      // first release edge: ready rises, request ignored
      req("rel", 0, 1, 1, 1, 1, 8'h99);
      for (int i = 0; i < 16; i++)
         req("rd0", 0, 1, 1, 0, i, 0);

      req("wrA5", 0, 1, 1, 1, 3, 8'hA5);
      req("rdA5", 0, 1, 1, 0, 3, 0);
      req("wr11", 0, 1, 1, 1, 7, 8'h11);
      req("rd11", 0, 1, 1, 0, 7, 0);

      for (int i = 0; i < 16; i++) begin
         req("altw", 0, 1, 1, 1, i, i ^ 8'h5A);
         req("altr", 0, 1, 1, 0, i, 0);
      end

      req("oorw", 0, 1, 1, 1, 20, 8'hFF);
      req("oorr", 0, 1, 1, 0, 20, 0);
      req("oorx", 0, 1, 1, 0, 31, 0);
      for (int i = 0; i < 16; i++)
         req("oorchk", 0, 1, 1, 0, i, 0);

      req("gate_en", 0, 0, 1, 1, 2, 8'h33);
      req("gate_v",  0, 1, 0, 1, 2, 8'h33);
      req("gate_rd", 0, 1, 1, 0, 2, 0);

      for (int i = 0; i < 400; i++) begin
         a = int'($urandom_range(0, 31));
         d = int'($urandom_range(0, 255));
         req("rand",
             ($urandom_range(0, 59) == 0),
             ($urandom_range(0, 7) != 0),
             ($urandom_range(0, 7) != 0),
             $urandom_range(0, 1) == 1,
             a, d);
      end

      req("mid_w",   0, 1, 1, 1, 5, 8'h77);
      req("mid_rst", 1, 1, 1, 0, 5, 0);
      req("mid_rel", 0, 0, 0, 0, 0, 0);
      req("mid_rd",  0, 1, 1, 0, 5, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
